// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per valid/ready handshake, LSB first,
// optional even/odd parity, one or two stop bits, back-to-back frames.
module uart_tx_param #(
  parameter int BAUD_DIV  = 10416,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_BITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 accept;
  logic                 baud_last;
  logic                 data_last;
  logic                 stop_last;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 2) ? ~^w : ^w;
  endfunction

  assign tx_ready  = (state == S_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign baud_last = (baud_cnt == BW'(BAUD_DIV - 1));
  assign data_last = (bit_cnt == CW'(DATA_BITS - 1));
  assign stop_last = (bit_cnt == CW'(STOP_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      TxD      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      // Decoded one cycle early so the registered pulse lands on the last stop clock.
      done <= (state == S_STOP) && stop_last && (baud_cnt == BW'(BAUD_DIV - 2));
      if (state == S_IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (accept) begin
          state <= S_START;
          TxD   <= 1'b0;
          busy  <= 1'b1;
        end
      end else if (!baud_last) begin
        baud_cnt <= baud_cnt + BW'(1);
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            TxD     <= shreg[0];
            bit_cnt <= '0;
          end
          S_DATA: begin
            if (!data_last) begin
              bit_cnt <= bit_cnt + CW'(1);
              TxD     <= shreg[1];
            end else begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                TxD   <= par_bit;
              end else begin
                state <= S_STOP;
                TxD   <= 1'b1;
              end
            end
          end
          S_PAR: begin
            state   <= S_STOP;
            TxD     <= 1'b1;
            bit_cnt <= '0;
          end
          S_STOP: begin
            if (!stop_last) begin
              bit_cnt <= bit_cnt + CW'(1);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            TxD   <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Payload path carries no reset; it is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= tx_data;
      par_bit <= parity_of(tx_data);
    end else if (state == S_DATA && baud_last && !data_last) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: several parameterisations share one clock
// and reset; expected line patterns are hand-built frame bit vectors.
module tb_uart_tx_param;

  logic       clk;
  logic       reset;
  logic [4:0] vld;
  logic [4:0] txd;
  logic [4:0] rdy;
  logic [4:0] bsy;
  logic [4:0] dn;
  logic [8:0] dat [5];

  int checks;
  int failures;

  logic [15:0] exp_a;
  logic [15:0] exp_b;
  logic        lvl;
  int          n;
  int          glitches;

  uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
    .tx_ready(rdy[0]), .TxD(txd[0]), .busy(bsy[0]), .done(dn[0]));

  uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
    .tx_ready(rdy[1]), .TxD(txd[1]), .busy(bsy[1]), .done(dn[1]));

  uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
    .tx_ready(rdy[2]), .TxD(txd[2]), .busy(bsy[2]), .done(dn[2]));

  uart_tx_param #(.BAUD_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tx_valid(vld[3]), .tx_data(dat[3][4:0]),
    .tx_ready(rdy[3]), .TxD(txd[3]), .busy(bsy[3]), .done(dn[3]));

  uart_tx_param #(.BAUD_DIV(10416), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u4 (
    .clk(clk), .reset(reset), .tx_valid(vld[4]), .tx_data(dat[4][7:0]),
    .tx_ready(rdy[4]), .TxD(txd[4]), .busy(bsy[4]), .done(dn[4]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // bits[k] is the expected line level during bit slot k of the frame.
  task automatic send_frame(input int i, input logic [8:0] word, input logic [15:0] bits,
                            input int nb, input int bd, input string tag);
    @(negedge clk);
    vld[i] = 1'b1;
    dat[i] = word;
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
    dat[i] = ~word;
    for (int c = 1; c <= nb * bd; c++) begin
      @(negedge clk);
      check($sformatf("%s_txd_c%0d", tag, c), txd[i], bits[(c - 1) / bd]);
      check($sformatf("%s_done_c%0d", tag, c), dn[i], (c == nb * bd));
      if (c == 1) begin
        check($sformatf("%s_ready_busy", tag), {rdy[i], bsy[i]}, 2'b01);
      end
    end
    @(negedge clk);
    check($sformatf("%s_after", tag), {rdy[i], bsy[i], dn[i], txd[i]}, 4'b1001);
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    vld      = '0;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 5; i++) dat[i] = '0;

    // Reset state and quiet idle line
    repeat (3) @(negedge clk);
    check("rst_held", {rdy[0], bsy[0], dn[0], txd[0]}, 4'b1001);
    reset = 1'b0;
    @(negedge clk);
    check("rst_released", {rdy, bsy, dn, txd}, {5'h1f, 5'h00, 5'h00, 5'h1f});
    glitches = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 5'h1f) glitches++;
    end
    check("idle_100_clks", glitches, 0);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send_frame(0, 9'h0A5, 16'h034A, 10, 4, "a5");

    // 0x07 with even (parity 1) and odd (parity 0) parity, 44 clks
    send_frame(1, 9'h007, 16'h060E, 11, 4, "even07");
    send_frame(2, 9'h007, 16'h040E, 11, 4, "odd07");

    // 5 data bits, 2 stop bits, valid held across two frames
    exp_a = 16'h00FE;
    exp_b = 16'h00C0;
    @(negedge clk);
    vld[3] = 1'b1;
    dat[3] = 9'h01F;
    @(posedge clk);
    #1;
    dat[3] = 9'h000;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      check($sformatf("b2b1_txd_c%0d", c), txd[3], exp_a[(c - 1) / 4]);
      check($sformatf("b2b1_done_c%0d", c), dn[3], (c == 32));
    end
    @(negedge clk);
    check("b2b_idle_gap", {rdy[3], bsy[3], txd[3]}, 3'b101);
    @(posedge clk);
    #1;
    vld[3] = 1'b0;
    dat[3] = 9'h01F;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      check($sformatf("b2b2_txd_c%0d", c), txd[3], exp_b[(c - 1) / 4]);
      check($sformatf("b2b2_done_c%0d", c), dn[3], (c == 32));
    end
    @(negedge clk);
    check("b2b_end", {rdy[3], bsy[3], txd[3]}, 3'b101);

    // Reset at clk 18 of a frame, then a clean 0x3C frame
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 9'h0A5;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (18) @(negedge clk);
    check("midrst_before", txd[0], 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_during", {rdy[0], bsy[0], dn[0], txd[0]}, 4'b1001);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_after", {rdy[0], bsy[0], txd[0]}, 3'b101);
    send_frame(0, 9'h03C, 16'h0278, 10, 4, "3c");

    // Full-rate divisor: first three bit slots of 0x55 measured edge to edge
    @(negedge clk);
    vld[4] = 1'b1;
    dat[4] = 9'h055;
    @(posedge clk);
    #1;
    vld[4] = 1'b0;
    @(negedge clk);
    for (int e = 0; e < 3; e++) begin
      lvl = txd[4];
      n   = 0;
      while (txd[4] == lvl && n < 12000) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("slow_level_%0d", e), lvl, e % 2);
      check($sformatf("slow_len_%0d", e), n, 10416);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("slow_abort", {rdy[4], txd[4]}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
